nios_multi_timer: RTL and testbench
===================================

Name: nios_multi_timer

Overview:
- Parametrised multi-channel interval timer for the Nios II peripheral set, on an Avalon-MM slave with a fixed one-cycle read latency.
- NUM_CH independent down-counters of width CNT_W, each with:
  - its own period, prescaler, snapshot, control and status;
  - continuous or one-shot mode.
- Per-channel timeouts are individually maskable and ORed onto one irq line to the CPU.

Parameters:
- NUM_CH, 2, number of timer channels (1..8).
- CNT_W, 32, counter/period/snapshot width in bits (8..32).
- PRE_W, 16, prescaler width in bits (1..16).
- PERIOD_RESET, 49999, reset value of every channel's PERIOD and counter (truncated to CNT_W).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- address  in  AW=$clog2(NUM_CH)+3 (min 3)  {channel, reg[2:0]}.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  OR over channels of (TO & ITO).

Behaviour:
- One clock, clk. Reset is asynchronous, active-low (reset_n); all state is cleared on assertion, with no clock needed.
- Reset values:
  - readdata=0, irq=0.
  - Per channel: counter=PERIOD=PERIOD_RESET, PRESCALE=0, pre_cnt=0, SNAP=0, CONTROL=0, RUN=0, TO=0.
- Write = chipselect & ~write_n. Writes take effect at the clock edge.
- Channel index ≥ NUM_CH: writes ignored, reads return 0.
- Register map (reg field):
  - 0 STATUS: bit0 TO, bit1 RUN. Any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT; bits[1:0] stored.
    - bit2 START, write-only pulse: RUN<=1.
    - bit3 STOP, write-only pulse: RUN<=0.
    - START and STOP both set: START wins.
  - 2 PERIOD: CNT_W bits. A write loads counter<=new PERIOD, pre_cnt<=PRESCALE, RUN<=0 in that same edge.
  - 3 SNAP: any write copies the current counter into SNAP; read returns SNAP.
  - 4 PRESCALE: PRE_W bits. The new value is used at the next prescaler reload; pre_cnt is not altered.
  - 5 COMPARE: see Optional Feature.
  - 6, 7: reserved, read 0.
- Readback is zero-extended to 32 bits.
- Reads: readdata <= mux(address) every cycle, regardless of chipselect. Data is valid in the cycle after the address is presented.
- Prescaler (per channel), while RUN=1:
  - pre_cnt==0: tick=1, pre_cnt<=PRESCALE.
  - Otherwise: pre_cnt-1, no tick.
  - While RUN=0: pre_cnt holds, tick=0.
- Counter (per channel), on tick:
  - counter==0: counter<=PERIOD, TO<=1; if CONT=0 then RUN<=0.
  - Otherwise: counter-1.
- Timeout interval: (PERIOD+1)*(PRESCALE+1) clocks. PERIOD=0 with PRESCALE=0 times out every clock.
- Arithmetic is modulo-free: the counter never wraps below 0, because reload happens at 0.
- Simultaneous events:
  - Timeout and STATUS write in the same cycle: TO ends 1 (event not lost).
  - Timeout and STOP in the same cycle: reload occurs, RUN=0.
  - PERIOD write and tick in the same cycle: the PERIOD write wins.
  - SNAP write captures the counter value before that edge's update.
- irq is combinational from registered TO/ITO. It stays asserted until TO is cleared or ITO is cleared.
- reset_n asserted mid-count: the channel returns to reset values and RUN=0. No timeout is produced on release.

Optional Feature:
- Macro: NIOS_MULTI_TIMER_PWM_EN.
- Defined:
  - Adds output pwm_out[NUM_CH-1:0], registered, reset 0.
  - Adds per-channel COMPARE at reg 5 (CNT_W bits, reset 0).
  - pwm_out[ch] <= RUN & (counter < COMPARE).
  - COMPARE=0 gives constant 0. COMPARE>PERIOD gives constant 1 while running.
- Undefined:
  - No pwm_out port and no COMPARE storage.
  - Reg 5 reads 0; writes to it are ignored.

Test Plan:
- Reset, then read every register of ch0/ch1 → PERIOD=49999, all others 0; readdata valid exactly 1 cycle after address; irq=0.
- ch0:
  - Stimulus: PERIOD=4, PRESCALE=0, CONTROL=0x7 (ITO|CONT|START).
  - Response: TO sets and irq rises every 5 clocks.
  - STATUS write clears TO, and irq falls next cycle.
  - A STATUS write coincident with a timeout leaves TO=1.
- ch1:
  - Stimulus: PERIOD=2, PRESCALE=3, CONTROL=0x5 (one-shot).
  - Response: one timeout after 12 clocks, then RUN=0; counter reloaded to 2 and held.
- Running ch0:
  - PERIOD write of 9 → RUN=0, counter=9 on the next read.
  - CONTROL=0xC (START+STOP) → RUN=1.
- SNAP write while ch0 counts down from 100 → SNAP holds the pre-edge value; a later read returns the same value while the counter keeps changing.
- With NIOS_MULTI_TIMER_PWM_EN: PERIOD=9, COMPARE=3, continuous → pwm_out[0] high 3 of every 10 clocks. Without the macro: reg 5 reads 0 after writing 0xFF.

Source files
------------

// File: rtl/nios_multi_timer.sv
// Multi-channel Avalon-MM interval timer with maskable per-channel timeout interrupts.
// Optional PWM outputs and per-channel COMPARE register: define NIOS_MULTI_TIMER_PWM_EN.
module nios_multi_timer #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 16,
  parameter int PERIOD_RESET = 49999,
  localparam int AW          = (NUM_CH > 1) ? $clog2(NUM_CH) + 3 : 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
`ifdef NIOS_MULTI_TIMER_PWM_EN
  output logic [NUM_CH-1:0] pwm_out,
`endif
  output logic              irq
);

  localparam logic [CNT_W-1:0] PER_RST = CNT_W'(PERIOD_RESET);

  logic              wr_en_s;
  logic [3:0]        ch_sel_s;
  logic [2:0]        reg_sel_s;
  logic [NUM_CH-1:0] to_v_s;
  logic [NUM_CH-1:0] ito_v_s;
  logic [31:0]       ch_rd_s [NUM_CH];
  logic [31:0]       rd_mux_s;

  assign wr_en_s   = chipselect & ~write_n;
  assign ch_sel_s  = 4'(address >> 3);
  assign reg_sel_s = address[2:0];
  assign irq       = |(to_v_s & ito_v_s);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] counter_r;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] snap_r;
    logic [PRE_W-1:0] prescale_r;
    logic [PRE_W-1:0] pre_cnt_r;
    logic             ito_r;
    logic             cont_r;
    logic             run_r;
    logic             to_r;
    logic             sel_s;
    logic             wr_status_s;
    logic             wr_ctrl_s;
    logic             wr_period_s;
    logic             wr_snap_s;
    logic             wr_presc_s;
    logic             tick_s;
    logic             wrap_s;
    logic [31:0]      rd_val_s;
`ifdef NIOS_MULTI_TIMER_PWM_EN
    logic [CNT_W-1:0] compare_r;
    logic             pwm_r;
    logic             wr_cmp_s;

    assign wr_cmp_s   = sel_s && (reg_sel_s == 3'd5);
    assign pwm_out[i] = pwm_r;

    // PWM compare register and registered PWM output
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        compare_r <= '0;
        pwm_r     <= 1'b0;
      end else begin
        if (wr_cmp_s) compare_r <= writedata[CNT_W-1:0];
        pwm_r <= run_r & (counter_r < compare_r);
      end
    end
`endif

    assign sel_s       = wr_en_s && (ch_sel_s == 4'(i));
    assign wr_status_s = sel_s && (reg_sel_s == 3'd0);
    assign wr_ctrl_s   = sel_s && (reg_sel_s == 3'd1);
    assign wr_period_s = sel_s && (reg_sel_s == 3'd2);
    assign wr_snap_s   = sel_s && (reg_sel_s == 3'd3);
    assign wr_presc_s  = sel_s && (reg_sel_s == 3'd4);
    assign tick_s      = run_r && (pre_cnt_r == '0);
    // A PERIOD write on the same edge overrides the reload and its timeout.
    assign wrap_s      = tick_s && (counter_r == '0) && !wr_period_s;

    // Channel registers, prescaler, down-counter and RUN/TO flags
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        counter_r  <= PER_RST;
        period_r   <= PER_RST;
        snap_r     <= '0;
        prescale_r <= '0;
        pre_cnt_r  <= '0;
        ito_r      <= 1'b0;
        cont_r     <= 1'b0;
        run_r      <= 1'b0;
        to_r       <= 1'b0;
      end else begin
        if (wr_period_s) period_r <= writedata[CNT_W-1:0];
        if (wr_presc_s) prescale_r <= writedata[PRE_W-1:0];
        if (wr_snap_s) snap_r <= counter_r;
        if (wr_ctrl_s) begin
          ito_r  <= writedata[0];
          cont_r <= writedata[1];
        end

        if (wr_period_s) begin
          counter_r <= writedata[CNT_W-1:0];
          pre_cnt_r <= prescale_r;
        end else if (tick_s) begin
          pre_cnt_r <= prescale_r;
          counter_r <= (counter_r == '0) ? period_r : counter_r - CNT_W'(1);
        end else if (run_r) begin
          pre_cnt_r <= pre_cnt_r - PRE_W'(1);
        end

        if (wrap_s) to_r <= 1'b1;
        else if (wr_status_s) to_r <= 1'b0;

        if (wr_period_s) run_r <= 1'b0;
        else if (wr_ctrl_s && writedata[2]) run_r <= 1'b1;
        else if (wr_ctrl_s && writedata[3]) run_r <= 1'b0;
        else if (wrap_s && !cont_r) run_r <= 1'b0;
      end
    end

    // Per-channel readback selection, zero-extended to the bus width
    always_comb begin
      rd_val_s = 32'd0;
      case (reg_sel_s)
        3'd0:    rd_val_s = {30'd0, run_r, to_r};
        3'd1:    rd_val_s = {30'd0, cont_r, ito_r};
        3'd2:    rd_val_s = 32'(period_r);
        3'd3:    rd_val_s = 32'(snap_r);
        3'd4:    rd_val_s = 32'(prescale_r);
`ifdef NIOS_MULTI_TIMER_PWM_EN
        3'd5:    rd_val_s = 32'(compare_r);
`endif
        default: rd_val_s = 32'd0;
      endcase
    end

    assign ch_rd_s[i]  = rd_val_s;
    assign to_v_s[i]   = to_r;
    assign ito_v_s[i]  = ito_r;
  end

  // Channel select; unpopulated channel indices read back as zero
  always_comb begin
    rd_mux_s = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      rd_mux_s = (ch_sel_s == 4'(i)) ? ch_rd_s[i] : rd_mux_s;
    end
  end

  // Registered read data, one-cycle latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= 32'd0;
    else readdata <= rd_mux_s;
  end

endmodule

// File: tb/tb_nios_multi_timer.sv
// Directed self-checking bench for nios_multi_timer (default parameters, 2 channels).
module tb_nios_multi_timer;

  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [AW-1:0] address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
`ifdef NIOS_MULTI_TIMER_PWM_EN
  logic [1:0]  pwm_out;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  nios_multi_timer dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
`ifdef NIOS_MULTI_TIMER_PWM_EN
    .pwm_out(pwm_out),
`endif
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic wr(input int ch, input int r, input logic [31:0] d);
    address    = AW'((ch << 3) | r);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Called at a negedge; data is sampled one cycle later.
  task automatic rd_chk(input int ch, input int r, input logic [31:0] exp, input string tag);
    logic [31:0] obs;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    address = AW'((ch << 3) | r);
    @(negedge clk);
    obs = readdata;
    chk(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = 32'd0;
    #1;
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 8; r++) begin
        rd_chk(c, r, (r == 2) ? 32'd49999 : 32'd0, $sformatf("reset_ch%0d_reg%0d", c, r));
      end
    end
    chk("reset_irq_after", {31'd0, irq}, 32'd0);
    address = AW'(2);
    #1;
    chk("rd_latency_early", readdata, 32'd0);
    @(negedge clk);
    chk("rd_latency_valid", readdata, 32'd49999);

    // ch0: period 4, continuous, interrupt enabled
    wr(0, 4, 32'd0);
    wr(0, 2, 32'd4);
    wr(0, 1, 32'h7);
    repeat (4) @(negedge clk);
    chk("ch0_irq_before_to", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("ch0_irq_first_to", {31'd0, irq}, 32'd1);
    wr(0, 0, 32'd0);
    chk("ch0_irq_cleared", {31'd0, irq}, 32'd0);
    repeat (3) @(negedge clk);
    chk("ch0_irq_before_to2", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("ch0_irq_second_to", {31'd0, irq}, 32'd1);
    repeat (4) @(negedge clk);
    wr(0, 0, 32'd0);
    chk("ch0_to_beats_clear", {31'd0, irq}, 32'd1);
    rd_chk(0, 0, 32'd3, "ch0_status_to_run");

    // PERIOD write on a running channel stops it and loads the counter
    wr(0, 2, 32'd9);
    rd_chk(0, 0, 32'd1, "ch0_period_wr_stops");
    wr(0, 3, 32'd0);
    rd_chk(0, 3, 32'd9, "ch0_counter_loaded");
    wr(0, 1, 32'hC);
    rd_chk(0, 0, 32'd3, "ch0_start_wins");
    rd_chk(0, 1, 32'd0, "ch0_control_bits");
    chk("ch0_irq_masked", {31'd0, irq}, 32'd0);

    // ch1: one-shot, period 2, prescale 3 -> timeout after 12 clocks
    wr(1, 4, 32'd3);
    wr(1, 2, 32'd2);
    wr(1, 1, 32'h5);
    repeat (11) @(negedge clk);
    chk("ch1_irq_before_to", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("ch1_irq_at_12", {31'd0, irq}, 32'd1);
    rd_chk(1, 0, 32'd1, "ch1_oneshot_stopped");
    repeat (10) @(negedge clk);
    wr(1, 3, 32'd0);
    rd_chk(1, 3, 32'd2, "ch1_counter_held");
    rd_chk(1, 0, 32'd1, "ch1_still_stopped");

    // SNAP captures the pre-edge counter while ch0 counts down from 100
    wr(0, 2, 32'd100);
    wr(0, 1, 32'h6);
    repeat (3) @(negedge clk);
    wr(0, 3, 32'd0);
    rd_chk(0, 3, 32'd97, "snap_first");
    repeat (5) @(negedge clk);
    rd_chk(0, 3, 32'd97, "snap_stable");
    wr(0, 3, 32'd0);
    rd_chk(0, 3, 32'd89, "snap_second");

`ifdef NIOS_MULTI_TIMER_PWM_EN
    wr(0, 2, 32'd9);
    wr(0, 5, 32'd3);
    wr(0, 1, 32'h6);
    rd_chk(0, 5, 32'd3, "compare_readback");
    repeat (3) @(negedge clk);
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pwm_out[0]) highs++;
    end
    chk("pwm_duty_6_of_20", 32'(highs), 32'd6);
`else
    highs = 0;
    wr(0, 5, 32'hFF);
    rd_chk(0, 5, 32'd0, "reg5_absent");
    chk("reg5_no_side_effect", 32'(highs), 32'd0);
`endif

    // Reset mid-count returns channel to reset values
    reset_n = 1'b0;
    #2;
    chk("midreset_irq", {31'd0, irq}, 32'd0);
    chk("midreset_readdata", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_chk(0, 0, 32'd0, "midreset_status");
    rd_chk(0, 2, 32'd49999, "midreset_period");
    repeat (5) @(negedge clk);
    rd_chk(1, 0, 32'd0, "midreset_ch1_status");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
